// File: rtl/add_sched_pkg.sv
// Shared definitions for the add_share_sched block.
//   state_e   : scheduler FSM states
//   HEX_SEG   : hex digit -> active-low segment pattern (abcdefg on bits 6..0)
//   SEG_BLANK : all segments off
package add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry 0 is the least significant slot, so the list runs F down to 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex to 7-segment decoder.
//   hex : 4-bit value to show
//   seg : segments a..g on bits 6..0, active-low
module hex_to_seg7
  import add_sched_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one external 4-bit adder between NREQ
// requesters, plus a scanned 7-segment display of each requester's last sum.
//   req/req_a/req_b  : per-requester request level and packed operands
//   gnt              : one-hot pulse, operands taken
//   res_*            : one-cycle result strobe with id, sum, carry
//   add_a/add_b      : registered operands to the shared adder
//   add_sum/add_carry: combinational adder result
//   digit_en/seg/seg_dp : multiplexed display, one digit per requester
module add_share_sched
  import add_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int SCAN_DIV = 16,
  localparam int IDW     = $clog2(NREQ),
  localparam int SCW     = $clog2(SCAN_DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [3:0]        res_sum,
  output logic              res_carry,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  input  logic [3:0]        add_sum,
  input  logic              add_carry,
  output logic [NREQ-1:0]   digit_en,
  output logic [6:0]        seg,
  output logic              seg_dp
);

  state_e                 state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [3:0]             add_a_q, add_a_d, add_b_q, add_b_d;
  logic [3:0]             sum_q, sum_d;
  logic                   carry_q, carry_d;
  logic [NREQ-1:0][3:0]   last_sum_q, last_sum_d;
  logic [NREQ-1:0]        last_carry_q, last_carry_d;
  logic [SCW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IDW-1:0]         digit_q, digit_d;

  logic                   pick_vld;
  logic [IDW-1:0]         pick_id;

  // First requester at or after rr_ptr. Scanning from the far end down lets
  // the closest candidate overwrite the others.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    last_sum_d   = last_sum_q;
    last_carry_d = last_carry_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          id_d    = pick_id;
          add_a_d = req_a[4*pick_id +: 4];
          add_b_d = req_b[4*pick_id +: 4];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        sum_d    = add_sum;
        carry_d  = add_carry;
        state_d  = CAPTURE;
      end
      CAPTURE: begin
        last_sum_d[id_q]   = sum_q;
        last_carry_d[id_q] = carry_q;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan, free-running.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      digit_d    = (digit_q == IDW'(NREQ - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      last_sum_q   <= '0;
      last_carry_q <= '0;
      scan_cnt_q   <= '0;
      digit_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      last_sum_q   <= last_sum_d;
      last_carry_q <= last_carry_d;
      scan_cnt_q   <= scan_cnt_d;
      digit_q      <= digit_d;
    end
  end

  // Strobes decode straight off the state register so reset clears them
  // without waiting for a clock.
  always_comb begin
    gnt = '0;
    if (state_q == ISSUE) gnt[id_q] = 1'b1;
    digit_en = '0;
    digit_en[digit_q] = 1'b1;
  end

  assign res_valid = (state_q == CAPTURE);
  assign res_id    = id_q;
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign seg_dp    = ~last_carry_q[digit_q];

  hex_to_seg7 u_hex (
    .hex (last_sum_q[digit_q]),
    .seg (seg)
  );

endmodule

// File: tb/tb_add_share_sched.sv
module tb_add_share_sched;

  localparam int NREQ = 4;
  localparam int SCAN_DIV = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]  gnt;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [3:0]       res_sum;
  logic             res_carry;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_carry;
  logic [NREQ-1:0]  digit_en;
  logic [6:0]       seg;
  logic             seg_dp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared bit_four_add instance.
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  add_share_sched #(.NREQ(NREQ), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_carry(res_carry), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_carry(add_carry), .digit_en(digit_en), .seg(seg), .seg_dp(seg_dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_digit(input logic [NREQ-1:0] d);
    int n;
    n = 0;
    while (digit_en !== d && n < NREQ * SCAN_DIV + 4) begin
      tick();
      n++;
    end
    chk("digit_reached", 32'(digit_en), 32'(d));
  endtask

  initial begin
    logic [NREQ-1:0] seen_gnt;
    logic [3:0] exp_sum [5];
    logic [1:0] exp_id  [5];

    req = '0; req_a = '0; req_b = '0;
    rst_n = 1'b0;
    #3;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res", {res_id, res_sum, res_carry}, 0);
    chk("rst_add", {add_a, add_b}, 0);
    chk("rst_digit_en", 32'(digit_en), 32'h1);
    chk("rst_seg", 32'(seg), 32'b0000001);
    chk("rst_dp", 32'(seg_dp), 1);
    #4 rst_n = 1'b1;

    // Idle scan: digit changes every SCAN_DIV edges.
    seen_gnt = '0;
    for (int d = 0; d < NREQ; d++) begin
      for (int c = 0; c < SCAN_DIV - 1; c++) begin
        tick();
        seen_gnt |= gnt;
      end
      chk("scan_hold", 32'(digit_en), 32'(1 << d));
      tick();
      seen_gnt |= gnt;
      chk("scan_step", 32'(digit_en), 32'(1 << ((d + 1) % NREQ)));
      chk("scan_seg", {seg, seg_dp}, {7'b0000001, 1'b1});
    end
    chk("idle_no_gnt", 32'(seen_gnt), 0);

    // req[2]: 5 + 2 = 7
    req = 4'b0100; req_a[11:8] = 4'h5; req_b[11:8] = 4'h2;
    tick();
    chk("r2_gnt", 32'(gnt), 32'b0100);
    chk("r2_novalid", 32'(res_valid), 0);
    req = '0;
    tick();
    chk("r2_valid", 32'(res_valid), 1);
    chk("r2_gnt_off", 32'(gnt), 0);
    chk("r2_res", {res_id, res_sum, res_carry}, {2'd2, 4'd7, 1'b0});
    tick();
    chk("r2_idle", 32'(res_valid), 0);
    wait_digit(4'b0100);
    chk("r2_seg", {seg, seg_dp}, {7'b0001111, 1'b1});

    // req[1]: B + B = 22 -> sum 6, carry 1
    req = 4'b0010; req_a[7:4] = 4'hB; req_b[7:4] = 4'hB;
    tick();
    chk("r1_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    chk("r1_res", {res_valid, res_id, res_sum, res_carry}, {1'b1, 2'd1, 4'd6, 1'b1});
    tick();
    wait_digit(4'b0010);
    chk("r1_seg", {seg, seg_dp}, {7'b0100000, 1'b0});

    // Fresh reset so the round-robin pointer starts at 0.
    rst_n = 1'b0; #2 rst_n = 1'b1;
    tick();

    // All held high: i+8 + 9 gives sums 1..4 with carry.
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(i + 8);
      req_b[4*i +: 4] = 4'h9;
    end
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sum = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1 << exp_id[g]));
      chk("rr_novalid", 32'(res_valid), 0);
      tick();
      chk("rr_res", {res_valid, res_id, res_sum, res_carry, gnt},
          {1'b1, exp_id[g], exp_sum[g], 1'b1, 4'b0000});
      tick();
      if (g == 4) req = '0;
      chk("rr_idle", {res_valid, gnt}, 0);
    end

    // rr_ptr now 1: req[3] beats req[0]; req[0] withdraws during that grant.
    req = 4'b1001;
    req_a[3:0] = 4'h1; req_b[3:0] = 4'h2;
    tick();
    chk("wd_gnt3", 32'(gnt), 32'b1000);
    req = '0;
    tick();
    chk("wd_res3", {res_valid, res_id}, {1'b1, 2'd3});
    seen_gnt = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_gnt |= gnt;
    end
    chk("wd_no_gnt0", 32'(seen_gnt), 0);
    req = 4'b0001;
    tick();
    chk("wd_regnt0", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    chk("wd_res0", {res_valid, res_id, res_sum, res_carry}, {1'b1, 2'd0, 4'd3, 1'b0});
    tick();

    // Reset during ISSUE discards the transaction.
    req = 4'b0010; req_a[7:4] = 4'hF; req_b[7:4] = 4'hF;
    tick();
    chk("mr_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt_clr", 32'(gnt), 0);
    chk("mr_valid_clr", 32'(res_valid), 0);
    req = '0;
    #1 rst_n = 1'b1;
    seen_gnt = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen_gnt |= gnt;
      chk("mr_no_capture", 32'(res_valid), 0);
    end
    chk("mr_no_gnt", 32'(seen_gnt), 0);
    wait_digit(4'b0010);
    chk("mr_last_sum", {seg, seg_dp}, {7'b0000001, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
